// File: rtl/parking_pkg.sv
// Shared constants and arbiter state encoding for the parking gate sensor front end.
package parking_pkg;

  localparam int unsigned SLOT_W              = 2;
  localparam int unsigned DEF_DEBOUNCE_CYCLES = 16;
  localparam int unsigned DEF_HOLDOFF_CYCLES  = 4;

  typedef enum logic [1:0] {
    StIdle  = 2'd0,
    StIssue = 2'd1,
    StHold  = 2'd2
  } arb_state_e;

endpackage

// File: rtl/sensor_debounce.sv
// Two-flop synchroniser plus stability counter for one sensor level and its optional data bus.
// A rising debounced transition raises o_rise for one cycle with o_data holding the stable data.
module sensor_debounce #(
  parameter int unsigned DEBOUNCE_CYCLES = 16,
  parameter int unsigned DATA_W          = 0,
  localparam int unsigned DW             = (DATA_W > 0) ? DATA_W : 1
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          i_level,
  input  logic [DW-1:0] i_data,
  output logic          o_level,
  output logic          o_rise,
  output logic [DW-1:0] o_data
);

  localparam int unsigned CNT_W = $clog2(DEBOUNCE_CYCLES + 1);

  logic             r_sync1, r_sync2, r_level, r_rise;
  logic [DW-1:0]    r_dsync1, r_dsync2, r_dprev, r_data;
  logic [CNT_W-1:0] r_cnt;
  logic             w_data_chg;

  assign w_data_chg = (r_dsync2 != r_dprev);

  always_ff @(posedge clk) begin
    if (reset) begin
      r_sync1  <= 1'b0;
      r_sync2  <= 1'b0;
      r_dsync1 <= '0;
      r_dsync2 <= '0;
      r_dprev  <= '0;
      r_level  <= 1'b0;
      r_rise   <= 1'b0;
      r_data   <= '0;
      r_cnt    <= '0;
    end else begin
      r_sync1  <= i_level;
      r_sync2  <= r_sync1;
      r_dsync1 <= i_data;
      r_dsync2 <= r_dsync1;
      r_dprev  <= r_dsync2;
      r_rise   <= 1'b0;
      // Any data movement restarts the window so the reported data is stable throughout it.
      if (w_data_chg) begin
        r_cnt <= '0;
      end else if (r_cnt == CNT_W'(DEBOUNCE_CYCLES)) begin
        r_cnt   <= '0;
        r_level <= ~r_level;
        r_rise  <= ~r_level;
        r_data  <= r_dsync2;
      end else if (r_sync2 != r_level) begin
        r_cnt <= r_cnt + 1'b1;
      end else begin
        r_cnt <= '0;
      end
    end
  end

  assign o_level = r_level;
  assign o_rise  = r_rise;
  assign o_data  = r_data;

endmodule

// File: rtl/parking_sensor_frontend.sv
// Debounces entry/exit gate sensors, queues one request per channel and issues single-cycle
// events to the occupancy FSM, exit first, with a hold-off after every event.
module parking_sensor_frontend
  import parking_pkg::*;
#(
  parameter int unsigned DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES,
  parameter int unsigned HOLDOFF_CYCLES  = DEF_HOLDOFF_CYCLES
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              raw_entry,
  input  logic              raw_exit,
  input  logic [SLOT_W-1:0] raw_exit_location,
  input  logic              clear_overrun,
  output logic              enable,
  output logic              entry_sensor,
  output logic              exit_sensor,
  output logic [SLOT_W-1:0] exit_location,
  output logic              entry_pending,
  output logic              exit_pending,
  output logic              overrun
);

  localparam int unsigned HOLD_W = $clog2(HOLDOFF_CYCLES + 1);

  logic              w_entry_level, w_entry_rise, w_exit_level, w_exit_rise;
  logic [0:0]        w_entry_data;
  logic [SLOT_W-1:0] w_exit_data;
  logic              w_grant_exit, w_grant_entry, w_ovr_set;

  logic              r_entry_pend, r_exit_pend, r_overrun;
  logic [SLOT_W-1:0] r_exit_loc;
  arb_state_e        r_state;
  logic [HOLD_W-1:0] r_hold_cnt;
  logic              r_enable, r_entry_sensor, r_exit_sensor;
  logic [SLOT_W-1:0] r_exit_location;

  sensor_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES), .DATA_W(0)) u_entry_db (
    .clk     (clk),
    .reset   (reset),
    .i_level (raw_entry),
    .i_data  (1'b0),
    .o_level (w_entry_level),
    .o_rise  (w_entry_rise),
    .o_data  (w_entry_data)
  );

  sensor_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES), .DATA_W(SLOT_W)) u_exit_db (
    .clk     (clk),
    .reset   (reset),
    .i_level (raw_exit),
    .i_data  (raw_exit_location),
    .o_level (w_exit_level),
    .o_rise  (w_exit_rise),
    .o_data  (w_exit_data)
  );

  assign w_grant_exit  = (r_state == StIdle) && r_exit_pend;
  assign w_grant_entry = (r_state == StIdle) && !r_exit_pend && r_entry_pend;
  // A fresh edge in the same cycle its channel is served simply re-queues.
  assign w_ovr_set = (w_entry_rise && r_entry_pend && !w_grant_entry) ||
                     (w_exit_rise && r_exit_pend && !w_grant_exit);

  always_ff @(posedge clk) begin
    if (reset) begin
      r_entry_pend <= 1'b0;
      r_exit_pend  <= 1'b0;
      r_exit_loc   <= '0;
      r_overrun    <= 1'b0;
    end else begin
      if (w_grant_entry)     r_entry_pend <= w_entry_rise;
      else if (w_entry_rise) r_entry_pend <= 1'b1;
      if (w_grant_exit)      r_exit_pend <= w_exit_rise;
      else if (w_exit_rise)  r_exit_pend <= 1'b1;
      if (w_exit_rise && (!r_exit_pend || w_grant_exit)) r_exit_loc <= w_exit_data;
      if (w_ovr_set)          r_overrun <= 1'b1;
      else if (clear_overrun) r_overrun <= 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state         <= StIdle;
      r_hold_cnt      <= '0;
      r_enable        <= 1'b0;
      r_entry_sensor  <= 1'b0;
      r_exit_sensor   <= 1'b0;
      r_exit_location <= '0;
    end else begin
      r_enable        <= 1'b0;
      r_entry_sensor  <= 1'b0;
      r_exit_sensor   <= 1'b0;
      r_exit_location <= '0;
      unique case (r_state)
        StIdle: begin
          if (w_grant_exit) begin
            r_state         <= StIssue;
            r_enable        <= 1'b1;
            r_exit_sensor   <= 1'b1;
            r_exit_location <= r_exit_loc;
          end else if (w_grant_entry) begin
            r_state        <= StIssue;
            r_enable       <= 1'b1;
            r_entry_sensor <= 1'b1;
          end
        end
        StIssue: begin
          r_state    <= StHold;
          r_hold_cnt <= '0;
        end
        StHold: begin
          if (r_hold_cnt == HOLD_W'(HOLDOFF_CYCLES - 1)) r_state <= StIdle;
          else r_hold_cnt <= r_hold_cnt + 1'b1;
        end
        default: r_state <= StIdle;
      endcase
    end
  end

  assign enable        = r_enable;
  assign entry_sensor  = r_entry_sensor;
  assign exit_sensor   = r_exit_sensor;
  assign exit_location = r_exit_location;
  assign entry_pending = r_entry_pend;
  assign exit_pending  = r_exit_pend;
  assign overrun       = r_overrun;

endmodule

// File: tb/tb_parking_sensor_frontend.sv
// Directed bench: main instance uses DEBOUNCE_CYCLES=4, HOLDOFF_CYCLES=3; a second instance with
// a long hold-off keeps an entry request waiting long enough for a second edge to overrun it.
module tb_parking_sensor_frontend;

  logic       clk = 1'b0;
  logic       reset, clear_overrun;
  logic       raw_entry, raw_exit, raw_entry2, raw_exit2;
  logic [1:0] raw_loc, raw_loc2;
  logic       en, ent, ext, epend, xpend, ovr;
  logic [1:0] loc;
  logic       en2, ent2, ext2, epend2, xpend2, ovr2;
  logic [1:0] loc2;

  int total = 0;
  int bad   = 0;
  int n_en  = 0;
  int n_ent2 = 0;
  int base;

  always #5 clk = ~clk;

  parking_sensor_frontend #(.DEBOUNCE_CYCLES(4), .HOLDOFF_CYCLES(3)) dut (
    .clk               (clk),
    .reset             (reset),
    .raw_entry         (raw_entry),
    .raw_exit          (raw_exit),
    .raw_exit_location (raw_loc),
    .clear_overrun     (clear_overrun),
    .enable            (en),
    .entry_sensor      (ent),
    .exit_sensor       (ext),
    .exit_location     (loc),
    .entry_pending     (epend),
    .exit_pending      (xpend),
    .overrun           (ovr)
  );

  parking_sensor_frontend #(.DEBOUNCE_CYCLES(4), .HOLDOFF_CYCLES(12)) dut_ovr (
    .clk               (clk),
    .reset             (reset),
    .raw_entry         (raw_entry2),
    .raw_exit          (raw_exit2),
    .raw_exit_location (raw_loc2),
    .clear_overrun     (clear_overrun),
    .enable            (en2),
    .entry_sensor      (ent2),
    .exit_sensor       (ext2),
    .exit_location     (loc2),
    .entry_pending     (epend2),
    .exit_pending      (xpend2),
    .overrun           (ovr2)
  );

  always @(negedge clk) begin
    if (en) n_en++;
    if (en2 && ent2) n_ent2++;
  end

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    total++;
    assert (obs === exp)
    else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  initial begin
    reset = 1'b1; clear_overrun = 1'b0;
    raw_entry = 1'b0; raw_exit = 1'b0; raw_loc = 2'b00;
    raw_entry2 = 1'b0; raw_exit2 = 1'b0; raw_loc2 = 2'b00;
    tick(3);
    chk("reset_outputs", {en, ent, ext, loc, epend, xpend, ovr}, 8'h00);
    chk("reset_outputs2", {en2, ent2, ext2, loc2, epend2, xpend2, ovr2}, 8'h00);
    reset = 1'b0;

    // 1: clean entry edge, enable DEBOUNCE_CYCLES+4 edges later
    base = n_en;
    raw_entry = 1'b1;
    tick(8);
    chk("t1_pending_before", {6'd0, epend, en}, 8'h02);
    tick(1);
    chk("t1_pulse", {5'd0, en, ent, ext}, 8'h06);
    chk("t1_loc", {6'd0, loc}, 8'h00);
    chk("t1_pending_cleared", {7'd0, epend}, 8'h00);
    tick(25);
    chk("t1_single_pulse", 8'(n_en - base), 8'd1);

    // 2: short exit glitch is filtered, then a held exit reports its slot
    raw_entry = 1'b0; raw_loc = 2'b10;
    tick(12);
    base = n_en;
    raw_exit = 1'b1;
    tick(3);
    raw_exit = 1'b0;
    tick(12);
    chk("t2_glitch_pending", {7'd0, xpend}, 8'h00);
    chk("t2_glitch_enable", 8'(n_en - base), 8'd0);
    raw_exit = 1'b1;
    tick(8);
    chk("t2_pending_before", {6'd0, xpend, en}, 8'h02);
    tick(1);
    chk("t2_pulse", {5'd0, en, ent, ext}, 8'h05);
    chk("t2_loc", {6'd0, loc}, 8'h02);
    tick(1);
    chk("t2_pulse_end", {5'd0, en, ent, ext}, 8'h00);
    raw_exit = 1'b0;
    tick(12);

    // 3: simultaneous edges, exit first then entry five cycles later
    raw_entry = 1'b1; raw_exit = 1'b1;
    tick(9);
    chk("t3_exit_pulse", {5'd0, en, ent, ext}, 8'h05);
    chk("t3_exit_loc", {6'd0, loc}, 8'h02);
    chk("t3_entry_waiting", {7'd0, epend}, 8'h01);
    tick(4);
    chk("t3_gap", {7'd0, en}, 8'h00);
    tick(1);
    chk("t3_entry_pulse", {5'd0, en, ent, ext}, 8'h06);
    chk("t3_entry_loc", {6'd0, loc}, 8'h00);
    raw_entry = 1'b0; raw_exit = 1'b0;
    tick(12);

    // 4: unstable slot code holds off the exit until it settles
    base = n_en;
    raw_exit = 1'b1;
    for (int i = 0; i < 8; i++) begin
      raw_loc = (i % 2 == 1) ? 2'b11 : 2'b01;
      tick(2);
    end
    chk("t4_no_pending", {7'd0, xpend}, 8'h00);
    chk("t4_no_enable", 8'(n_en - base), 8'd0);
    tick(7);
    chk("t4_pending_before", {6'd0, xpend, en}, 8'h02);
    tick(1);
    chk("t4_pulse", {5'd0, en, ent, ext}, 8'h05);
    chk("t4_loc", {6'd0, loc}, 8'h03);
    raw_exit = 1'b0;
    tick(12);

    // 5: second entry edge while the first still waits behind a long hold-off
    raw_entry2 = 1'b1; raw_exit2 = 1'b1;
    tick(6);
    raw_entry2 = 1'b0;
    tick(6);
    raw_entry2 = 1'b1;
    tick(7);
    chk("t5_no_overrun_yet", {7'd0, ovr2}, 8'h00);
    tick(1);
    chk("t5_overrun", {6'd0, ovr2, epend2}, 8'h03);
    tick(6);
    chk("t5_one_entry_pulse", 8'(n_ent2), 8'd1);
    chk("t5_pending_cleared", {7'd0, epend2}, 8'h00);
    chk("t5_overrun_sticky", {7'd0, ovr2}, 8'h01);
    clear_overrun = 1'b1;
    tick(1);
    clear_overrun = 1'b0;
    chk("t5_overrun_cleared", {7'd0, ovr2}, 8'h00);

    // 6: reset during hold-off drops the queued entry
    raw_entry = 1'b1; raw_exit = 1'b1;
    tick(10);
    chk("t6_entry_queued", {6'd0, epend, en}, 8'h02);
    reset = 1'b1; raw_entry = 1'b0; raw_exit = 1'b0;
    tick(1);
    chk("t6_reset_outputs", {en, ent, ext, loc, epend, xpend, ovr}, 8'h00);
    reset = 1'b0;
    base = n_en;
    tick(20);
    chk("t6_no_pulse", 8'(n_en - base), 8'd0);
    chk("t6_no_pending", {6'd0, epend, xpend}, 8'h00);
    raw_entry = 1'b1;
    tick(9);
    chk("t6_idle_latency", {5'd0, en, ent, ext}, 8'h06);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/parking_sensor_frontend.md
Name: parking_sensor_frontend

Overview:
Conditions the raw gate sensors and feeds the parking occupancy FSM.
- Synchronises and debounces the entry and exit photo-sensors and the exit slot code.
- Converts each debounced rising edge into a pending request.
- Arbitrates pending requests and issues exactly one single-cycle, registered event (enable + entry_sensor or exit_sensor + exit_location) per accepted car, then enforces a hold-off before the next event.

Parameters:
DEBOUNCE_CYCLES, 16, consecutive stable cycles of a synchronised input before the debounced level changes (>=1).
HOLDOFF_CYCLES, 4, idle cycles inserted after every issued event (>=1).

Ports:
clk  input  1  system clock
reset  input  1  synchronous, active-high reset
raw_entry  input  1  asynchronous entry-lane sensor
raw_exit  input  1  asynchronous exit-lane sensor
raw_exit_location  input  2  asynchronous slot code of the exiting car
clear_overrun  input  1  synchronous clear for overrun
enable  output  1  one-cycle event strobe to occupancy FSM
entry_sensor  output  1  entry event (valid with enable)
exit_sensor  output  1  exit event (valid with enable)
exit_location  output  2  slot of exit event (valid with exit_sensor)
entry_pending  output  1  entry request waiting
exit_pending  output  1  exit request waiting
overrun  output  1  sticky: edge arrived while same channel already pending

Behaviour:
- One clock, clk. reset is synchronous and active-high, sampled on the rising edge of clk.
- Reset: all outputs 0, exit_location 2'b00, synchroniser flops and debounced levels 0, counters 0, arbiter in IDLE. Reset asserted mid-event or mid-hold-off aborts immediately and drops pending requests.
- Synchroniser: two flops per bit on raw_entry, raw_exit and raw_exit_location[1:0].
- Debounce, per channel:
  - Counter width $clog2(DEBOUNCE_CYCLES+1).
  - Counter increments while the synced level differs from the debounced level. It clears when they match.
  - When the counter reaches DEBOUNCE_CYCLES, the debounced level toggles and the counter clears.
  - Exit channel: the counter also clears on any change of the synced location. This guarantees the location is stable for the full window.
  - A debounced 0->1 transition is an event. Falling transitions produce nothing.
- Pending:
  - An event sets its pending flag; an exit event also latches the synced location.
  - An event on a channel already pending sets overrun. The flag stays set and the latched location is unchanged.
  - overrun clears only on clear_overrun or reset. An event with overrun set in the same cycle as clear_overrun leaves overrun=1.
- Arbiter states: IDLE, ISSUE, HOLD.
  - IDLE:
    - exit_pending -> ISSUE(exit). Exit has priority so that capacity is freed first.
    - else entry_pending -> ISSUE(entry).
    - else stay in IDLE.
  - ISSUE (exactly 1 cycle):
    - Registered outputs: enable=1, plus exactly one of entry_sensor/exit_sensor =1.
    - exit_location = latched location on exit; 2'b00 on entry.
    - The served pending flag clears. A new event on the same channel in this cycle re-sets the flag and does not raise overrun.
    - Next state: HOLD.
  - HOLD: enable and both sensor outputs 0 for HOLDOFF_CYCLES cycles, then IDLE. Events still accumulate as pending.
- Both pending at IDLE: exit is issued, then the entry after hold-off. Minimum spacing between enable pulses = HOLDOFF_CYCLES+1 cycles; IDLE adds one further cycle before the next ISSUE.
- Latency, idle arbiter, clean edge: raw rise sampled at edge 0 -> enable high after edge DEBOUNCE_CYCLES+4 (2 sync, DEBOUNCE_CYCLES debounce, 1 pending, 1 issue).
- The block carries no occupancy knowledge. Invalid exits and full-lot entries are forwarded, and the downstream FSM rejects them.

Decomposition:
- Shared package parking_pkg:
  - SLOT_W=2.
  - Arbiter state encoding: IDLE=2'd0, ISSUE=2'd1, HOLD=2'd2.
  - Default DEBOUNCE_CYCLES and HOLDOFF_CYCLES constants.
- Sub-module sensor_debounce (parameters DEBOUNCE_CYCLES and DATA_W):
  - Contains the 2-flop synchroniser, counter and rising-edge detect.
  - Outputs a debounced level, a rise pulse and stable data.
  - Instantiated twice: entry with DATA_W=0, exit with DATA_W=2.

Test Plan:
1. DEBOUNCE_CYCLES=4, HOLDOFF_CYCLES=3; raw_entry 0->1 held -> single enable+entry_sensor pulse 8 cycles after the edge; pending clears; no second pulse while held high.
2. raw_exit glitch high for 3 cycles -> no pending, no enable. Then held 10 cycles with raw_exit_location=2'b10 -> one pulse with exit_sensor=1, exit_location=2'b10.
3. Entry and exit rise in the same cycle -> exit pulse first; entry pulse exactly 5 cycles later (3 HOLD, 1 IDLE, 1 ISSUE).
4. Exit location toggles 01/11 every 2 cycles while raw_exit high -> no event until the location is stable 4 cycles; the final stable value is issued.
5. Second entry edge debounced while entry_pending=1 -> overrun=1 and only one entry pulse. clear_overrun -> overrun=0 next cycle.
6. reset asserted during HOLD with entry pending -> next cycle all outputs 0, pending cleared, state IDLE; no pulse after reset release without a new edge.
